// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the CPU program loader: FSM state codes, frame
// TARGET codes and word/byte widths.
package cpu_loader_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_SYNC    = 3'd0;
    localparam state_t ST_TARGET  = 3'd1;
    localparam state_t ST_ADDR    = 3'd2;
    localparam state_t ST_COUNT   = 3'd3;
    localparam state_t ST_DATA_HI = 3'd4;
    localparam state_t ST_DATA_LO = 3'd5;
    localparam state_t ST_CSUM    = 3'd6;
    localparam state_t ST_RUN     = 3'd7;

    localparam logic [BYTE_W-1:0] TGT_IROM = 8'h00;
    localparam logic [BYTE_W-1:0] TGT_DROM = 8'h01;
    localparam logic [BYTE_W-1:0] TGT_END  = 8'hFF;

endpackage

// File: rtl/loader_image_bank.sv
// Register array holding one memory image for the CPU.
// Ports:
//   clk, rst  - clock, asynchronous active-high clear (all words -> 0)
//   we        - write strobe; writes wdata to word 'ptr' if ptr < DEPTH
//   ptr       - 8-bit word pointer
//   wdata     - 16-bit word to write
//   flat      - all words, word k at bits [16k+15:16k]
module loader_image_bank
    import cpu_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [BYTE_W-1:0]         ptr,
    input  logic [WORD_W-1:0]         wdata,
    output logic [WORD_W*DEPTH-1:0]   flat
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Decoded write: out-of-range pointers match no entry and are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ptr == BYTE_W'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign flat[g*WORD_W +: WORD_W] = mem[g];
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Byte-stream program loader: parses framed writes into the CPU's
// instruction and data images and holds the CPU in reset until a clean
// END command is accepted.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   in_data    - stream byte; transfer when in_valid && in_ready
//   in_valid   - in_data valid this cycle
//   in_ready   - loader accepts a byte (low in RUN and during reset)
//   irom_flat  - instruction image, word k at [16k+15:16k]
//   drom_flat  - data image, word k at [16k+15:16k]
//   cpu_rst    - CPU reset, high until a clean END is accepted
//   load_err   - sticky error flag, cleared only by rst
//   load_done  - high once RUN is reached
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned      IMEM_DEPTH = 20,
    parameter int unsigned      DMEM_DEPTH = 20,
    parameter logic [7:0]       SYNC_BYTE  = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BYTE_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WORD_W*IMEM_DEPTH-1:0]   irom_flat,
    output logic [WORD_W*DMEM_DEPTH-1:0]   drom_flat,
    output logic                           cpu_rst,
    output logic                           load_err,
    output logic                           load_done
);

    state_t              state;
    state_t              state_nxt;
    logic [BYTE_W-1:0]   ptr;
    logic [BYTE_W-1:0]   cnt;
    logic [BYTE_W-1:0]   csum;
    logic [BYTE_W-1:0]   hi;
    logic                tgt_drom;
    logic                accept;
    logic                in_range;
    logic                wr_irom;
    logic                wr_drom;
    logic [WORD_W-1:0]   wdata;

    assign accept   = in_valid && in_ready;
    assign in_range = tgt_drom ? (ptr < BYTE_W'(DMEM_DEPTH))
                               : (ptr < BYTE_W'(IMEM_DEPTH));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every transition requires an accepted byte
    always_comb begin
        state_nxt = state;
        if (accept) begin
            unique case (state)
                ST_SYNC: begin
                    if (in_data == SYNC_BYTE) state_nxt = ST_TARGET;
                end
                ST_TARGET: begin
                    if (in_data == TGT_IROM || in_data == TGT_DROM) begin
                        state_nxt = ST_ADDR;
                    end else if (in_data == TGT_END && !load_err) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_SYNC;
                    end
                end
                ST_ADDR:    state_nxt = ST_COUNT;
                ST_COUNT:   state_nxt = (in_data == '0) ? ST_CSUM : ST_DATA_HI;
                ST_DATA_HI: state_nxt = ST_DATA_LO;
                ST_DATA_LO: state_nxt = (cnt == 8'd1) ? ST_CSUM : ST_DATA_HI;
                ST_CSUM:    state_nxt = ST_SYNC;
                ST_RUN:     state_nxt = ST_RUN;
                default:    state_nxt = ST_SYNC;
            endcase
        end
    end

    // Output decode: handshake and image write strobes
    always_comb begin
        in_ready = 1'b0;
        wr_irom  = 1'b0;
        wr_drom  = 1'b0;
        wdata    = {hi, in_data};
        if (!rst && state != ST_RUN) begin
            in_ready = 1'b1;
        end
        if (accept && state == ST_DATA_LO && in_range) begin
            wr_irom = !tgt_drom;
            wr_drom = tgt_drom;
        end
    end

    // Frame datapath: pointer, count, running XOR, flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            csum      <= '0;
            hi        <= '0;
            tgt_drom  <= 1'b0;
            load_err  <= 1'b0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_TARGET: begin
                    if (in_data == TGT_IROM || in_data == TGT_DROM) begin
                        tgt_drom <= (in_data == TGT_DROM);
                    end else if (in_data == TGT_END) begin
                        // An END after any error only resynchronises.
                        if (!load_err) begin
                            cpu_rst   <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end else begin
                        load_err <= 1'b1;
                    end
                end
                ST_ADDR:  ptr <= in_data;
                ST_COUNT: cnt <= in_data;
                ST_DATA_HI: begin
                    hi   <= in_data;
                    csum <= csum ^ in_data;
                end
                ST_DATA_LO: begin
                    csum <= csum ^ in_data;
                    if (!in_range) load_err <= 1'b1;
                    ptr <= ptr + 8'd1;
                    cnt <= cnt - 8'd1;
                end
                ST_CSUM: begin
                    if (in_data != csum) load_err <= 1'b1;
                    csum <= '0;
                end
                default: ;
            endcase
        end
    end

    loader_image_bank #(.DEPTH(IMEM_DEPTH)) u_irom (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_irom),
        .ptr   (ptr),
        .wdata (wdata),
        .flat  (irom_flat)
    );

    loader_image_bank #(.DEPTH(DMEM_DEPTH)) u_drom (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_drom),
        .ptr   (ptr),
        .wdata (wdata),
        .flat  (drom_flat)
    );

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader. Frames are expanded into byte entries, each
// tagged with the effect the byte must have; applying those effects to
// plain arrays gives the expected images and flags every cycle.
module tb_cpu_program_loader;

    localparam int D  = 20;
    localparam int FW = 16 * D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] irom_flat;
    logic [FW-1:0] drom_flat;
    logic          cpu_rst;
    logic          load_err;
    logic          load_done;

    cpu_program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .irom_flat (irom_flat),
        .drom_flat (drom_flat),
        .cpu_rst   (cpu_rst),
        .load_err  (load_err),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        bit          wr;
        bit          drom;
        int          idx;
        logic [15:0] val;
        bit          err;
        bit          is_end;
    } ent_t;

    ent_t        q[$];
    ent_t        cur;
    bit          have_cur = 0;
    bit          tog = 0;
    logic [15:0] wq[$];

    logic [15:0] exp_irom [D];
    logic [15:0] exp_drom [D];
    bit          exp_err;
    bit          exp_done;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_img(input bit drom);
        logic [FW-1:0] f;
        for (int k = 0; k < D; k++) f[16*k +: 16] = drom ? exp_drom[k] : exp_irom[k];
        return f;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) begin
            exp_irom[k] = '0;
            exp_drom[k] = '0;
        end
        exp_err  = 0;
        exp_done = 0;
    endtask

    task automatic apply(input ent_t e);
        if (e.wr) begin
            if (e.drom) exp_drom[e.idx] = e.val;
            else        exp_irom[e.idx] = e.val;
        end
        if (e.err) exp_err = 1;
        if (e.is_end && !exp_err) exp_done = 1;
    endtask

    task automatic compare_all();
        chk("irom_flat", irom_flat, pack_img(0));
        chk("drom_flat", drom_flat, pack_img(1));
        chk("load_err",  FW'(load_err),  FW'(exp_err));
        chk("load_done", FW'(load_done), FW'(exp_done));
        chk("cpu_rst",   FW'(cpu_rst),   FW'(!exp_done));
        chk("in_ready",  FW'(in_ready),  FW'(!exp_done));
    endtask

    task automatic push_raw(input logic [7:0] b);
        ent_t e;
        e = '{data: b, wr: 0, drom: 0, idx: 0, val: '0, err: 0, is_end: 0};
        q.push_back(e);
    endtask

    // Expand one frame (words taken from wq) into tagged byte entries.
    task automatic add_frame(input logic [7:0] tgt, input logic [7:0] addr, input bit bad_csum);
        ent_t       e;
        logic [7:0] x;
        int         p;
        push_raw(8'hA5);
        e = '{data: tgt, wr: 0, drom: 0, idx: 0, val: '0, err: 0, is_end: 0};
        if (tgt == 8'hFF)      e.is_end = 1;
        else if (tgt > 8'h01)  e.err = 1;
        q.push_back(e);
        if (tgt > 8'h01) begin
            wq.delete();
            return;
        end
        push_raw(addr);
        push_raw(8'(wq.size()));
        x = '0;
        foreach (wq[i]) begin
            push_raw(wq[i][15:8]);
            e = '{data: wq[i][7:0], wr: 0, drom: 0, idx: 0, val: '0, err: 0, is_end: 0};
            p = (int'(addr) + i) % 256;
            if (p < D) begin
                e.wr = 1; e.drom = tgt[0]; e.idx = p; e.val = wq[i];
            end else begin
                e.err = 1;
            end
            q.push_back(e);
            x = x ^ wq[i][15:8] ^ wq[i][7:0];
        end
        e = '{data: x, wr: 0, drom: 0, idx: 0, val: '0, err: 0, is_end: 0};
        if (bad_csum) begin
            e.data = x ^ 8'($urandom_range(1, 255));
            e.err  = 1;
        end
        q.push_back(e);
        wq.delete();
    endtask

    // One clock: drive at negedge, model acceptance at posedge, compare at negedge.
    task automatic step(input int mode);
        bit v;
        if (!have_cur && q.size() > 0) begin
            cur = q.pop_front();
            have_cur = 1;
        end
        case (mode)
            0:       v = ($urandom_range(3) != 0);
            1:       begin tog = !tog; v = tog; end
            default: v = 1;
        endcase
        in_valid = have_cur && v;
        in_data  = in_valid ? cur.data : 8'($urandom);
        @(posedge clk);
        if (in_valid && !exp_done) begin
            apply(cur);
            have_cur = 0;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_queue(input int mode, input int budget);
        int n = 0;
        while ((have_cur || q.size() > 0) && n < budget) begin
            step(mode);
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (have_cur || q.size() > 0) begin
            errors++;
            $display("FAIL queue_drain pending=%0d budget=%0d", q.size(), budget);
            q.delete();
            have_cur = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        have_cur = 0;
        tog = 0;
        model_clear();
        #1;
        chk("rst_irom",     irom_flat, '0);
        chk("rst_drom",     drom_flat, '0);
        chk("rst_cpu_rst",  FW'(cpu_rst),   FW'(1));
        chk("rst_in_ready", FW'(in_ready),  FW'(0));
        chk("rst_err",      FW'(load_err),  FW'(0));
        chk("rst_done",     FW'(load_done), FW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        model_clear();
        @(negedge clk);
        do_reset();

        // Basic instruction load then END
        wq.push_back(16'h6024);
        add_frame(8'h00, 8'h00, 0);
        run_queue(2, 50);
        chk("basic_w0",       FW'(irom_flat[15:0]), FW'(16'h6024));
        chk("basic_model_w0", FW'(exp_irom[0]),     FW'(16'h6024));
        add_frame(8'hFF, 8'h00, 0);
        run_queue(2, 50);
        idle(3);
        chk("basic_err",   FW'(load_err),  FW'(0));
        chk("basic_done",  FW'(load_done), FW'(1));
        chk("basic_cpu",   FW'(cpu_rst),   FW'(0));
        chk("basic_ready", FW'(in_ready),  FW'(0));

        // Data load
        do_reset();
        wq.push_back(16'h0142);
        wq.push_back(16'h000A);
        add_frame(8'h01, 8'h01, 0);
        run_queue(2, 50);
        chk("data_w1",   FW'(drom_flat[31:16]), FW'(16'h0142));
        chk("data_w2",   FW'(drom_flat[47:32]), FW'(16'h000A));
        chk("data_rest", drom_flat & ~(FW'(32'hFFFF_FFFF) << 16), '0);
        chk("data_err",  FW'(load_err), FW'(0));

        // Bad checksum: word stays, END refused
        do_reset();
        wq.push_back(16'hFFFF);
        add_frame(8'h00, 8'h03, 1);
        run_queue(2, 50);
        chk("badcs_w3",  FW'(irom_flat[63:48]), FW'(16'hFFFF));
        chk("badcs_err", FW'(load_err), FW'(1));
        add_frame(8'hFF, 8'h00, 0);
        run_queue(2, 50);
        idle(2);
        chk("badcs_cpu",   FW'(cpu_rst),  FW'(1));
        chk("badcs_ready", FW'(in_ready), FW'(1));

        // Out of range: second word dropped
        do_reset();
        wq.push_back(16'h1111);
        wq.push_back(16'h2222);
        add_frame(8'h00, 8'h13, 0);
        run_queue(2, 50);
        chk("oor_w19",  FW'(irom_flat[FW-1 -: 16]), FW'(16'h1111));
        chk("oor_rest", FW'(irom_flat[FW-17:0]),   '0);
        chk("oor_err",  FW'(load_err), FW'(1));

        // Sync hunt with alternating stalls
        do_reset();
        push_raw(8'h00);
        push_raw(8'h37);
        wq.push_back(16'h1234);
        add_frame(8'h00, 8'h05, 0);
        run_queue(1, 100);
        chk("hunt_w5",  FW'(irom_flat[95:80]), FW'(16'h1234));
        chk("hunt_err", FW'(load_err), FW'(0));

        // Reset mid-frame, then a clean reload
        do_reset();
        push_raw(8'hA5); push_raw(8'h00); push_raw(8'h00);
        push_raw(8'h01); push_raw(8'h60);
        run_queue(2, 50);
        do_reset();
        wq.push_back(16'hBEEF);
        add_frame(8'h00, 8'h00, 0);
        add_frame(8'hFF, 8'h00, 0);
        run_queue(2, 50);
        chk("rerun_w0",   FW'(irom_flat[15:0]), FW'(16'hBEEF));
        chk("rerun_done", FW'(load_done), FW'(1));

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            int nf;
            do_reset();
            nf = $urandom_range(1, 5);
            for (int f = 0; f < nf; f++) begin
                int r;
                logic [7:0] tgt;
                logic [7:0] addr;
                int cnt;
                if ($urandom_range(3) == 0) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    push_raw(b);
                end
                r = $urandom_range(15);
                tgt = (r == 0) ? 8'($urandom_range(2, 254)) : 8'(r % 2);
                addr = ($urandom_range(7) == 0) ? 8'($urandom_range(250, 255))
                                                : 8'($urandom_range(0, 22));
                cnt = $urandom_range(0, 4);
                for (int w = 0; w < cnt; w++) wq.push_back(16'($urandom));
                add_frame(tgt, addr, ($urandom_range(7) == 0));
            end
            add_frame(8'hFF, 8'h00, 0);
            run_queue(0, 2000);
            idle(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
